id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
//  ID/EX pipeline register that feeds alu32bit in the 32-bit pipelined core.
//  - Captures decoded operands and control.
//  - Decodes ALUOp/funct into the 4-bit ALUControl.
//  - Applies EX/MEM and MEM/WB forwarding so that a, b and ALUControl connect straight to alu32bit.
//  - Supports stall (hold) and flush (bubble) from the hazard unit.
// PARAMETERS
//  WIDTH   32  datapath width of operands, immediate and forwarded results
//  RADDR    5  register-address width
// PORTS
//  clk              in   1      rising-edge clock, the only clock
//  reset            in   1      synchronous, active-high
//  stall            in   1      hold all stage registers
//  flush            in   1      load a bubble on the next edge
//  id_valid         in   1      ID slot holds a real instruction
//  id_rs_data       in   WIDTH  register-file read data, rs
//  id_rt_data       in   WIDTH  register-file read data, rt
//  id_imm           in   WIDTH  sign-extended immediate
//  id_rs/id_rt/id_rd in  RADDR  register addresses
//  id_alu_op        in   2      00 add, 01 sub, 10 R-type(funct), 11 and
//  id_funct         in   6      instruction funct field
//  id_alu_src       in   1      1: b = immediate
//  id_reg_dst       in   1      1: dest = rd, 0: dest = rt
//  id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in 1 each  control pass-through
//  exmem_reg_write  in   1      EX/MEM writes a register
//  exmem_rd         in   RADDR  EX/MEM destination
//  exmem_result     in   WIDTH  EX/MEM ALU result
//  memwb_reg_write  in   1      MEM/WB writes a register
//  memwb_rd         in   RADDR  MEM/WB destination
//  memwb_result     in   WIDTH  MEM/WB write-back data
//  a                out  WIDTH  ALU operand a (forwarded rs)
//  b                out  WIDTH  ALU operand b (immediate or forwarded rt)
//  ALUControl       out  4      0000 AND, 0001 OR, 0010 add, 0110 sub, 0111 slt
//  ex_store_data    out  WIDTH  forwarded rt, for stores
//  ex_dest          out  RADDR  selected destination register
//  ex_valid         out  1      stage holds a real instruction
//  ex_illegal       out  1      registered: R-type with unsupported funct
//  ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out 1 each  registered control
// BEHAVIOUR
//  Reset (clk edge with reset=1):
//   - All stage registers clear to 0; ex_valid=0, ALUControl=0000.
//   - Outputs a, b, ex_store_data and ex_dest = 0 when exmem/memwb inputs do not forward.
//  Priority on each edge: reset > flush > stall > load.
//   - flush: ex_valid=0; every control bit, ex_illegal and ALUControl clear; data regs may hold any value.
//   - stall (no flush): every register holds its value.
//   - load: capture all id_* inputs. ex_valid = id_valid.
//   - id_valid=0 loads as a bubble: same clear as flush.
//  Latency: 1 cycle ID->EX. Forwarding and the b mux are combinational on the registered fields.
//  ALU decode is computed at capture and registered:
//   - alu_op 00 -> 0010; 01 -> 0110; 11 -> 0000.
//   - alu_op 10 with funct: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 101010 -> 0111.
//   - Any other funct -> 1111 with ex_illegal=1; ex_reg_write is forced 0 for that instruction.
//  Forwarding (each of rs_q and rt_q separately):
//   - Use exmem_result if exmem_reg_write && exmem_rd==addr && addr!=0.
//   - Else use memwb_result if memwb_reg_write && memwb_rd==addr && addr!=0.
//   - Else use the registered read data. EX/MEM wins over MEM/WB when both match.
//   - Register 0 is never forwarded.
//  b = alu_src_q ? imm_q : fwd_rt. ex_store_data = fwd_rt always.
//  ex_dest = reg_dst_q ? rd_q : rt_q. No arithmetic here; widths pass through unchanged.
//  Stall and flush both asserted: flush wins. Reset asserted mid-stall: reset wins.
// TESTING
//  1 Reset: reset=1 for 2 edges -> ex_valid=0, ALUControl=0000, all ex_* control=0.
//  2 Decode: R-type funct 101010, rs=h00001111, rt=h01101111 -> next cycle ALUControl=0111, a/b match.
//    Illegal funct 000111 -> ALUControl=1111, ex_illegal=1, ex_reg_write=0.
//  3 Forwarding: rs=3, exmem(rw=1, rd=3, h10101111) and memwb(rw=1, rd=3, hDEAD0000) -> a=h10101111.
//    With exmem_rw=0 -> a=hDEAD0000. rs=0 with rd=0 matches -> a=id_rs_data.
//  4 Immediate: alu_src=1, imm=hFFFFFFFC, alu_op=00 -> b=hFFFFFFFC, ALUControl=0010.
//    ex_store_data = forwarded rt.
//  5 Stall: load instr A, hold stall=1 for 3 cycles while ID changes -> outputs stay A.
//    Release -> next ID captured.
//  6 Flush: stall=1 and flush=1 together -> ex_valid=0, control=0, ALUControl=0000.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage for the 32-bit pipelined core.
// Registers the decoded instruction fields and turns ALUOp/funct into the
// 4-bit ALU control code. EX/MEM and MEM/WB results are then forwarded
// onto the registered operands, so a, b and ALUControl can drive alu32bit
// directly. The hazard unit can hold the stage (stall) or insert a bubble
// (flush).
module id_ex_operand_stage #(
    parameter int WIDTH = 32,
    parameter int RADDR = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [WIDTH-1:0] id_rs_data,
    input  logic [WIDTH-1:0] id_rt_data,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [RADDR-1:0] id_rs,
    input  logic [RADDR-1:0] id_rt,
    input  logic [RADDR-1:0] id_rd,
    input  logic [1:0]       id_alu_op,
    input  logic [5:0]       id_funct,
    input  logic             id_alu_src,
    input  logic             id_reg_dst,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_mem_to_reg,
    input  logic             exmem_reg_write,
    input  logic [RADDR-1:0] exmem_rd,
    input  logic [WIDTH-1:0] exmem_result,
    input  logic             memwb_reg_write,
    input  logic [RADDR-1:0] memwb_rd,
    input  logic [WIDTH-1:0] memwb_result,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [3:0]       ALUControl,
    output logic [WIDTH-1:0] ex_store_data,
    output logic [RADDR-1:0] ex_dest,
    output logic             ex_valid,
    output logic             ex_illegal,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_mem_to_reg
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_BAD = 4'b1111;

    // Returns {illegal, alu_control}. Only R-type can be illegal.
    function automatic logic [4:0] alu_decode(input logic [1:0] op, input logic [5:0] fn);
        logic [4:0] r;
        r = {1'b0, ALU_ADD};
        case (op)
            2'b00: r = {1'b0, ALU_ADD};
            2'b01: r = {1'b0, ALU_SUB};
            2'b11: r = {1'b0, ALU_AND};
            default: begin
                case (fn)
                    6'b100000: r = {1'b0, ALU_ADD};
                    6'b100010: r = {1'b0, ALU_SUB};
                    6'b100100: r = {1'b0, ALU_AND};
                    6'b100101: r = {1'b0, ALU_OR};
                    6'b101010: r = {1'b0, ALU_SLT};
                    default:   r = {1'b1, ALU_BAD};
                endcase
            end
        endcase
        return r;
    endfunction

    // EX/MEM has the younger result, so it is checked before MEM/WB.
    // Register 0 is hard-wired and never forwarded.
    function automatic logic [WIDTH-1:0] forward_operand(
        input logic [RADDR-1:0] addr,
        input logic [WIDTH-1:0] rf_data,
        input logic             near_we,
        input logic [RADDR-1:0] near_rd,
        input logic [WIDTH-1:0] near_data,
        input logic             far_we,
        input logic [RADDR-1:0] far_rd,
        input logic [WIDTH-1:0] far_data
    );
        logic [WIDTH-1:0] r;
        r = rf_data;
        if (addr != '0) begin
            if (near_we && (near_rd == addr)) begin
                r = near_data;
            end else if (far_we && (far_rd == addr)) begin
                r = far_data;
            end
        end
        return r;
    endfunction

    // ---- ID: decode ahead of the stage register ----
    logic [4:0] id_decode;
    logic       id_bad;

    assign id_decode = alu_decode(id_alu_op, id_funct);
    assign id_bad    = id_decode[4];

    // ---- ID -> EX stage register (_p1) ----
    logic             vld_p1;
    logic             illegal_p1;
    logic [3:0]       alu_ctrl_p1;
    logic             reg_write_p1;
    logic             mem_read_p1;
    logic             mem_write_p1;
    logic             mem_to_reg_p1;
    logic             alu_src_p1;
    logic             reg_dst_p1;
    logic [WIDTH-1:0] rs_data_p1;
    logic [WIDTH-1:0] rt_data_p1;
    logic [WIDTH-1:0] imm_p1;
    logic [RADDR-1:0] rs_p1;
    logic [RADDR-1:0] rt_p1;
    logic [RADDR-1:0] rd_p1;

    // Control fields: reset, flush and an invalid ID slot all produce a bubble.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            vld_p1        <= 1'b0;
            illegal_p1    <= 1'b0;
            alu_ctrl_p1   <= ALU_AND;
            reg_write_p1  <= 1'b0;
            mem_read_p1   <= 1'b0;
            mem_write_p1  <= 1'b0;
            mem_to_reg_p1 <= 1'b0;
            alu_src_p1    <= 1'b0;
            reg_dst_p1    <= 1'b0;
        end else if (!stall) begin
            if (id_valid) begin
                vld_p1        <= 1'b1;
                illegal_p1    <= id_bad;
                alu_ctrl_p1   <= id_decode[3:0];
                reg_write_p1  <= id_reg_write && !id_bad;
                mem_read_p1   <= id_mem_read;
                mem_write_p1  <= id_mem_write;
                mem_to_reg_p1 <= id_mem_to_reg;
                alu_src_p1    <= id_alu_src;
                reg_dst_p1    <= id_reg_dst;
            end else begin
                vld_p1        <= 1'b0;
                illegal_p1    <= 1'b0;
                alu_ctrl_p1   <= ALU_AND;
                reg_write_p1  <= 1'b0;
                mem_read_p1   <= 1'b0;
                mem_write_p1  <= 1'b0;
                mem_to_reg_p1 <= 1'b0;
                alu_src_p1    <= 1'b0;
                reg_dst_p1    <= 1'b0;
            end
        end
    end

    // Operand and address fields: cleared on reset, frozen on stall and flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            rs_data_p1 <= '0;
            rt_data_p1 <= '0;
            imm_p1     <= '0;
            rs_p1      <= '0;
            rt_p1      <= '0;
            rd_p1      <= '0;
        end else if (!flush && !stall) begin
            rs_data_p1 <= id_rs_data;
            rt_data_p1 <= id_rt_data;
            imm_p1     <= id_imm;
            rs_p1      <= id_rs;
            rt_p1      <= id_rt;
            rd_p1      <= id_rd;
        end
    end

    // ---- EX: forwarding and operand muxes on the registered fields ----
    logic [WIDTH-1:0] fwd_rs;
    logic [WIDTH-1:0] fwd_rt;

    assign fwd_rs = forward_operand(rs_p1, rs_data_p1,
                                    exmem_reg_write, exmem_rd, exmem_result,
                                    memwb_reg_write, memwb_rd, memwb_result);
    assign fwd_rt = forward_operand(rt_p1, rt_data_p1,
                                    exmem_reg_write, exmem_rd, exmem_result,
                                    memwb_reg_write, memwb_rd, memwb_result);

    assign a             = fwd_rs;
    assign b             = alu_src_p1 ? imm_p1 : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign ex_dest       = reg_dst_p1 ? rd_p1 : rt_p1;

    assign ALUControl    = alu_ctrl_p1;
    assign ex_valid      = vld_p1;
    assign ex_illegal    = illegal_p1;
    assign ex_reg_write  = reg_write_p1;
    assign ex_mem_read   = mem_read_p1;
    assign ex_mem_write  = mem_write_p1;
    assign ex_mem_to_reg = mem_to_reg_p1;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Testbench for id_ex_operand_stage: directed scenarios plus randomized
// traffic checked against a behavioural model of the ID/EX stage.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [1:0]  id_alu_op;
    logic [5:0]  id_funct;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] a, b, ex_store_data;
    logic [3:0]  alu_control;
    logic [4:0]  ex_dest;
    logic        ex_valid, ex_illegal, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage #(.WIDTH(32), .RADDR(5)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_alu_op(id_alu_op), .id_funct(id_funct),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .a(a), .b(b), .ALUControl(alu_control), .ex_store_data(ex_store_data),
        .ex_dest(ex_dest), .ex_valid(ex_valid), .ex_illegal(ex_illegal),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
    );

    // Behavioural model: the instruction currently held in EX.
    logic        m_valid, m_ill, m_rw, m_mr, m_mw, m_mtr, m_alu_src, m_reg_dst, m_known;
    logic [3:0]  m_ctrl;
    logic [31:0] m_rs_data, m_rt_data, m_imm;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [31:0] exp_a, exp_b, exp_store;
    logic [4:0]  exp_dest;
    logic [9:0]  exp_ctl, got_ctl;

    function automatic bit ref_legal(input logic [1:0] op, input logic [5:0] fn);
        if (op != 2'b10) return 1'b1;
        return fn == 6'd32 || fn == 6'd34 || fn == 6'd36 || fn == 6'd37 || fn == 6'd42;
    endfunction

    function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [5:0] fn);
        if (op == 2'b00) return 4'd2;
        if (op == 2'b01) return 4'd6;
        if (op == 2'b11) return 4'd0;
        if (fn == 6'd32) return 4'd2;
        if (fn == 6'd34) return 4'd6;
        if (fn == 6'd36) return 4'd0;
        if (fn == 6'd37) return 4'd1;
        if (fn == 6'd42) return 4'd7;
        return 4'd15;
    endfunction

    function automatic logic [31:0] fwd_ref(input logic [4:0] addr, input logic [31:0] rf);
        if (addr == 5'd0) return rf;
        if (exmem_reg_write && exmem_rd == addr) return exmem_result;
        if (memwb_reg_write && memwb_rd == addr) return memwb_result;
        return rf;
    endfunction

    task automatic model_bubble();
        m_valid = 0; m_ill = 0; m_ctrl = 4'd0;
        m_rw = 0; m_mr = 0; m_mw = 0; m_mtr = 0; m_known = 0;
    endtask

    // One clock edge; the model takes the inputs present at that edge.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            model_bubble();
            m_alu_src = 0; m_reg_dst = 0;
            m_rs_data = 0; m_rt_data = 0; m_imm = 0; m_rs = 0; m_rt = 0; m_rd = 0;
            m_known = 1;
        end else if (flush) begin
            model_bubble();
        end else if (stall) begin
            // EX keeps its instruction
        end else if (!id_valid) begin
            model_bubble();
        end else begin
            m_valid = 1;
            m_ill = !ref_legal(id_alu_op, id_funct);
            m_ctrl = ref_ctrl(id_alu_op, id_funct);
            m_rw = id_reg_write && !m_ill;
            m_mr = id_mem_read; m_mw = id_mem_write; m_mtr = id_mem_to_reg;
            m_alu_src = id_alu_src; m_reg_dst = id_reg_dst;
            m_rs_data = id_rs_data; m_rt_data = id_rt_data; m_imm = id_imm;
            m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
            m_known = 1;
        end
        #1;
    endtask

    task automatic model_eval();
        exp_a = fwd_ref(m_rs, m_rs_data);
        exp_store = fwd_ref(m_rt, m_rt_data);
        exp_b = m_alu_src ? m_imm : exp_store;
        exp_dest = m_reg_dst ? m_rd : m_rt;
        exp_ctl = {m_valid, m_ill, m_ctrl, m_rw, m_mr, m_mw, m_mtr};
        got_ctl = {ex_valid, ex_illegal, alu_control, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg};
    endtask

    task automatic drive_idle();
        reset = 0; stall = 0; flush = 0; id_valid = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_alu_op = 0; id_funct = 0; id_alu_src = 0; id_reg_dst = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    task automatic drive_random_id();
        id_valid = 1;
        id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
        id_rs = 5'($urandom_range(0, 4)); id_rt = 5'($urandom_range(0, 4)); id_rd = 5'($urandom);
        id_alu_op = 2'($urandom);
        id_funct = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'(32 + 2 * $urandom_range(0, 5));
        id_alu_src = 1'($urandom); id_reg_dst = 1'($urandom);
        id_reg_write = 1'($urandom); id_mem_read = 1'($urandom);
        id_mem_write = 1'($urandom); id_mem_to_reg = 1'($urandom);
    endtask

    task automatic test_reset();
        drive_idle();
        id_valid = 1; id_reg_write = 1; id_mem_read = 1; id_alu_op = 2'b01;
        reset = 1;
        tick();
        tick();
        reset = 0;
        got_ctl = {ex_valid, ex_illegal, alu_control, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg};
        checks++;
        if (got_ctl !== 10'd0) begin
            errors++; $display("FAIL reset_ctl: got %b expected %b", got_ctl, 10'd0);
        end
        checks++;
        if ({a, b, ex_store_data, ex_dest} !== 101'd0) begin
            errors++; $display("FAIL reset_data: a=%h b=%h st=%h dest=%0d expected all 0", a, b, ex_store_data, ex_dest);
        end
    endtask

    task automatic test_decode();
        drive_idle();
        id_valid = 1; id_alu_op = 2'b10; id_funct = 6'b101010; id_reg_write = 1;
        id_rs = 5'd1; id_rt = 5'd2; id_rs_data = 32'h00001111; id_rt_data = 32'h01101111;
        tick();
        checks++;
        if (alu_control !== 4'b0111 || a !== 32'h00001111 || b !== 32'h01101111) begin
            errors++; $display("FAIL decode_slt: ctrl=%b a=%h b=%h expected 0111 00001111 01101111", alu_control, a, b);
        end
        id_funct = 6'b000111;
        tick();
        checks++;
        if (alu_control !== 4'b1111 || ex_illegal !== 1'b1 || ex_reg_write !== 1'b0) begin
            errors++; $display("FAIL decode_illegal: ctrl=%b ill=%b rw=%b expected 1111 1 0", alu_control, ex_illegal, ex_reg_write);
        end
        // every alu_op/funct combination against the reference decode
        for (int op = 0; op < 4; op++) begin
            for (int fn = 0; fn < 64; fn++) begin
                id_alu_op = 2'(op); id_funct = 6'(fn);
                tick();
                model_eval();
                checks++;
                if (got_ctl !== exp_ctl) begin
                    errors++; $display("FAIL decode_sweep op=%0d fn=%0d: got %b expected %b", op, fn, got_ctl, exp_ctl);
                end
            end
        end
    endtask

    task automatic test_forwarding();
        drive_idle();
        id_valid = 1; id_rs = 5'd3; id_rt = 5'd4; id_rs_data = 32'h12345678; id_rt_data = 32'h0BADF00D;
        tick();
        exmem_reg_write = 1; exmem_rd = 5'd3; exmem_result = 32'h10101111;
        memwb_reg_write = 1; memwb_rd = 5'd3; memwb_result = 32'hDEAD0000;
        #1;
        checks++;
        if (a !== 32'h10101111) begin
            errors++; $display("FAIL fwd_exmem_wins: got %h expected %h", a, 32'h10101111);
        end
        exmem_reg_write = 0;
        #1;
        checks++;
        if (a !== 32'hDEAD0000) begin
            errors++; $display("FAIL fwd_memwb: got %h expected %h", a, 32'hDEAD0000);
        end
        checks++;
        if (b !== 32'h0BADF00D || ex_store_data !== 32'h0BADF00D) begin
            errors++; $display("FAIL fwd_rt_none: b=%h st=%h expected 0badf00d", b, ex_store_data);
        end
        memwb_rd = 5'd4;
        #1;
        checks++;
        if (b !== 32'hDEAD0000 || ex_store_data !== 32'hDEAD0000 || a !== 32'h12345678) begin
            errors++; $display("FAIL fwd_rt_memwb: a=%h b=%h st=%h expected 12345678 dead0000 dead0000", a, b, ex_store_data);
        end
        id_rs = 5'd0; id_rs_data = 32'hCAFEF00D;
        tick();
        exmem_reg_write = 1; exmem_rd = 5'd0; memwb_reg_write = 1; memwb_rd = 5'd0;
        #1;
        checks++;
        if (a !== 32'hCAFEF00D) begin
            errors++; $display("FAIL fwd_reg0: got %h expected %h", a, 32'hCAFEF00D);
        end
    endtask

    task automatic test_immediate();
        drive_idle();
        id_valid = 1; id_alu_src = 1; id_imm = 32'hFFFFFFFC; id_alu_op = 2'b00;
        id_rt = 5'd7; id_rt_data = 32'h00000055; id_rd = 5'd9; id_reg_dst = 0;
        tick();
        exmem_reg_write = 1; exmem_rd = 5'd7; exmem_result = 32'h77770007;
        #1;
        checks++;
        if (b !== 32'hFFFFFFFC || alu_control !== 4'b0010) begin
            errors++; $display("FAIL imm_b: b=%h ctrl=%b expected fffffffc 0010", b, alu_control);
        end
        checks++;
        if (ex_store_data !== 32'h77770007 || ex_dest !== 5'd7) begin
            errors++; $display("FAIL imm_store: st=%h dest=%0d expected 77770007 7", ex_store_data, ex_dest);
        end
    endtask

    task automatic test_stall();
        logic [31:0] a0, b0;
        drive_idle();
        id_valid = 1; id_alu_op = 2'b01; id_reg_write = 1; id_mem_write = 1; id_reg_dst = 1;
        id_rs = 5'd5; id_rt = 5'd6; id_rd = 5'd12;
        id_rs_data = 32'hA5A5A5A5; id_rt_data = 32'h5A5A5A5A;
        a0 = id_rs_data; b0 = id_rt_data;
        tick();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            drive_random_id();
            tick();
            checks++;
            if (a !== a0 || b !== b0 || ex_dest !== 5'd12 || alu_control !== 4'b0110 ||
                ex_valid !== 1'b1 || ex_reg_write !== 1'b1 || ex_mem_write !== 1'b1) begin
                errors++; $display("FAIL stall_hold[%0d]: a=%h b=%h dest=%0d ctrl=%b v=%b expected %h %h 12 0110 1",
                                   i, a, b, ex_dest, alu_control, ex_valid, a0, b0);
            end
        end
        stall = 0;
        drive_random_id();
        id_alu_op = 2'b11; id_alu_src = 0;
        tick();
        model_eval();
        checks++;
        if (a !== id_rs_data || b !== id_rt_data || alu_control !== 4'b0000 || got_ctl !== exp_ctl) begin
            errors++; $display("FAIL stall_release: a=%h b=%h ctl=%b expected %h %h %b", a, b, got_ctl, id_rs_data, id_rt_data, exp_ctl);
        end
    endtask

    task automatic test_flush();
        drive_idle();
        id_valid = 1; id_alu_op = 2'b10; id_funct = 6'b100101; id_reg_write = 1; id_mem_read = 1; id_mem_to_reg = 1;
        tick();
        stall = 1; flush = 1;
        tick();
        got_ctl = {ex_valid, ex_illegal, alu_control, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg};
        checks++;
        if (got_ctl !== 10'd0) begin
            errors++; $display("FAIL flush_over_stall: got %b expected %b", got_ctl, 10'd0);
        end
        // bubble from an invalid ID slot
        stall = 0; flush = 0;
        tick();
        id_valid = 0;
        tick();
        got_ctl = {ex_valid, ex_illegal, alu_control, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg};
        checks++;
        if (got_ctl !== 10'd0) begin
            errors++; $display("FAIL bubble_load: got %b expected %b", got_ctl, 10'd0);
        end
        // reset while stalled
        id_valid = 1; id_rs = 5'd2; id_rs_data = 32'h13579BDF;
        tick();
        stall = 1; reset = 1;
        tick();
        reset = 0; stall = 0;
        checks++;
        if (ex_valid !== 1'b0 || a !== 32'd0 || ex_reg_write !== 1'b0) begin
            errors++; $display("FAIL reset_mid_stall: v=%b a=%h rw=%b expected 0 0 0", ex_valid, a, ex_reg_write);
        end
    endtask

    task automatic test_random();
        drive_idle();
        for (int i = 0; i < 400; i++) begin
            drive_random_id();
            id_valid = ($urandom_range(0, 4) != 0);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 39) == 0);
            tick();
            exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 4)); exmem_result = $urandom;
            memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 4)); memwb_result = $urandom;
            #1;
            model_eval();
            checks++;
            if (got_ctl !== exp_ctl) begin
                errors++; $display("FAIL rand_ctl[%0d]: got %b expected %b", i, got_ctl, exp_ctl);
            end
            if (m_known) begin
                checks++;
                if (a !== exp_a || b !== exp_b || ex_store_data !== exp_store || ex_dest !== exp_dest) begin
                    errors++; $display("FAIL rand_data[%0d]: a=%h b=%h st=%h d=%0d expected %h %h %h %0d",
                                       i, a, b, ex_store_data, ex_dest, exp_a, exp_b, exp_store, exp_dest);
                end
            end
        end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_decode();
        test_forwarding();
        test_immediate();
        test_stall();
        test_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule
